// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD adder.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam bcd_digit_t BCD_MAX  = 4'd9;
    localparam bcd_digit_t BCD_CORR = 4'd6;

endpackage

// File: rtl/bcd_digit_adder.sv
// One-digit BCD adder: binary sum of two digits plus carry, decimal-corrected.
module bcd_digit_adder
    import bcd_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       cin,
    output bcd_digit_t s,
    output logic       cout
);

    logic [4:0] raw;

    assign raw = {1'b0, a} + {1'b0, b} + {4'd0, cin};

    always_comb begin
        s    = raw[3:0];
        cout = 1'b0;
        if (raw > {1'b0, BCD_MAX}) begin
            // Adding 6 skips the six unused codes; the wrap past 15 is the decimal carry.
            s    = raw[3:0] + BCD_CORR;
            cout = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial BCD adder: one shared digit adder walks the operands LSD first.
// Define BCD_INVALID_CHECK_EN to reject operands containing digits above 9.
module bcd_serial_add_ctrl
    import bcd_pkg::*;
#(
    parameter int NDIGITS = 4
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic                   start,
    input  logic [4*NDIGITS-1:0]   a,
    input  logic [4*NDIGITS-1:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [4*NDIGITS-1:0]   sum,
    output logic                   cout,
    output logic                   err
);

    localparam int IDXW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NDIGITS - 1);

    state_t state, state_n;

    logic [NDIGITS-1:0][3:0] opa, opb, sum_r;
    logic [IDXW-1:0]         idx;
    logic                    carry;
    logic                    accept;
    logic                    bad;
    bcd_digit_t              dsum;
    logic                    dcout;

    bcd_digit_adder u_digit (
        .a    (opa[idx]),
        .b    (opb[idx]),
        .cin  (carry),
        .s    (dsum),
        .cout (dcout)
    );

`ifdef BCD_INVALID_CHECK_EN
    logic err_r;

    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (a[i*4 +: 4] > BCD_MAX || b[i*4 +: 4] > BCD_MAX)
                bad = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset)
            err_r <= 1'b0;
        else if (accept)
            err_r <= bad;
    end

    assign err = err_r;
`else
    assign bad = 1'b0;
    assign err = 1'b0;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_n = bad ? DONE : ADD;
                end
            end
            ADD:     if (idx == LAST) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Sum and carry are cleared at capture, so a rejected operand pair reports 0.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            opa   <= '0;
            opb   <= '0;
            sum_r <= '0;
            carry <= 1'b0;
            idx   <= '0;
        end else if (accept) begin
            opa   <= a;
            opb   <= b;
            sum_r <= '0;
            carry <= 1'b0;
            idx   <= '0;
        end else if (state == ADD) begin
            sum_r[idx] <= dsum;
            carry      <= dcout;
            idx        <= idx + 1'b1;
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign sum  = sum_r;
    assign cout = carry;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Directed self-checking bench for bcd_serial_add_ctrl (NDIGITS=4).
module tb_bcd_serial_add_ctrl;

    logic        CLOCK_50 = 1'b0;
    logic        reset    = 1'b1;
    logic        start    = 1'b0;
    logic [15:0] a        = '0;
    logic [15:0] b        = '0;
    logic        busy, done, cout, err;
    logic [15:0] sum;

    int checks = 0;
    int errors = 0;

    bcd_serial_add_ctrl #(.NDIGITS(4)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .err      (err)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Start on one edge; lat = edge index (start sample = 1) at which done is seen, -1 on timeout.
    task automatic run_op(input logic [15:0] av, input logic [15:0] bv, output int lat);
        bit got = 0;
        @(negedge CLOCK_50);
        a = av; b = bv; start = 1'b1;
        @(posedge CLOCK_50);
        lat = -1;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge CLOCK_50);
            start = 1'b0;
            if (done) begin
                got = 1;
                lat = k + 2;
            end else begin
                @(posedge CLOCK_50);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        checks++;
        if ({busy, done, cout, err} !== 4'b0000 || sum !== 16'h0000) begin
            errors++;
            $display("FAIL reset_state busy=%b done=%b cout=%b err=%b sum=%h required all zero", busy, done, cout, err, sum);
        end
        reset = 1'b0;
    endtask

    task automatic test_add();
        int lat;
        run_op(16'h1234, 16'h8766, lat);
        checks++;
        if (lat !== 6) begin errors++; $display("FAIL add_latency got %0d required 6", lat); end
        checks++;
        if ({cout, err, sum} !== {2'b10, 16'h0000}) begin
            errors++; $display("FAIL add_1234_8766 sum=%h cout=%b err=%b required 0000 1 0", sum, cout, err);
        end
        run_op(16'h4821, 16'h3179, lat);
        checks++;
        if ({cout, sum} !== {1'b0, 16'h8000}) begin
            errors++; $display("FAIL add_4821_3179 sum=%h cout=%b required 8000 0", sum, cout);
        end
        // Results must hold after DONE.
        repeat (3) @(negedge CLOCK_50);
        checks++;
        if ({busy, done, cout, sum} !== {3'b000, 16'h8000}) begin
            errors++; $display("FAIL hold_after_done busy=%b done=%b sum=%h cout=%b required 0 0 8000 0", busy, done, sum, cout);
        end
    endtask

    task automatic test_carry_edges();
        int lat;
        run_op(16'h9999, 16'h0001, lat);
        checks++;
        if ({cout, sum} !== {1'b1, 16'h0000}) begin
            errors++; $display("FAIL add_9999_0001 sum=%h cout=%b required 0000 1", sum, cout);
        end
        run_op(16'h0000, 16'h0000, lat);
        checks++;
        if ({lat, cout, sum} !== {32'd6, 1'b0, 16'h0000}) begin
            errors++; $display("FAIL add_zero lat=%0d sum=%h cout=%b required 6 0000 0", lat, sum, cout);
        end
    endtask

    task automatic test_ignore_start();
        int dones = 0;
        logic [15:0] dsum = 'x;
        logic dcout = 1'bx;
        @(negedge CLOCK_50);
        a = 16'h0456; b = 16'h0123; start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        @(negedge CLOCK_50);
        a = 16'h9999; start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        for (int k = 0; k < 14; k++) begin
            if (done) begin dones++; dsum = sum; dcout = cout; end
            @(negedge CLOCK_50);
        end
        checks++;
        if (dones !== 1) begin errors++; $display("FAIL restart_ignored done_count=%0d required 1", dones); end
        checks++;
        if ({dcout, dsum} !== {1'b0, 16'h0579}) begin
            errors++; $display("FAIL restart_result sum=%h cout=%b required 0579 0", dsum, dcout);
        end
    endtask

    task automatic test_input_hold();
        int lat;
        @(negedge CLOCK_50);
        a = 16'h0001; b = 16'h0002; start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0; a = 16'h9999; b = 16'h9999;
        lat = 0;
        for (int k = 0; k < 12 && lat == 0; k++) begin
            @(negedge CLOCK_50);
            if (done) lat = 1;
        end
        checks++;
        if ({lat[0], cout, sum} !== {1'b1, 1'b0, 16'h0003}) begin
            errors++; $display("FAIL input_hold seen=%0d sum=%h cout=%b required 1 0003 0", lat, sum, cout);
        end
    endtask

    task automatic test_abort();
        int dones = 0;
        run_op(16'h5555, 16'h4444, dones);
        dones = 0;
        @(negedge CLOCK_50);
        a = 16'h1111; b = 16'h2222; start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        @(negedge CLOCK_50);
        reset = 1'b1;
        @(negedge CLOCK_50);
        checks++;
        if ({busy, done, cout, sum} !== {3'b000, 16'h0000}) begin
            errors++; $display("FAIL abort_state busy=%b done=%b cout=%b sum=%h required 0 0 0 0000", busy, done, cout, sum);
        end
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLOCK_50);
            if (done || busy) dones++;
        end
        checks++;
        if (dones !== 0) begin errors++; $display("FAIL abort_no_done active_cycles=%0d required 0", dones); end
    endtask

    task automatic test_invalid_digit();
        int lat;
        run_op(16'h00A0, 16'h0000, lat);
`ifdef BCD_INVALID_CHECK_EN
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL invalid_latency got %0d required 2", lat); end
        checks++;
        if ({err, cout, sum} !== {2'b10, 16'h0000}) begin
            errors++; $display("FAIL invalid_flags err=%b cout=%b sum=%h required 1 0 0000", err, cout, sum);
        end
`else
        checks++;
        if (lat !== 6) begin errors++; $display("FAIL invalid_latency got %0d required 6", lat); end
        checks++;
        if ({err, cout, sum} !== {2'b00, 16'h0100}) begin
            errors++; $display("FAIL invalid_flags err=%b cout=%b sum=%h required 0 0 0100", err, cout, sum);
        end
`endif
        run_op(16'h0025, 16'h0017, lat);
        checks++;
        if ({err, cout, sum} !== {2'b00, 16'h0042}) begin
            errors++; $display("FAIL err_cleared err=%b cout=%b sum=%h required 0 0 0042", err, cout, sum);
        end
    endtask

    task automatic test_back_to_back();
        int t1 = -1, t2 = -1, idle_busy = 0;
        logic [15:0] s1 = 'x, s2 = 'x;
        @(negedge CLOCK_50);
        a = 16'h0025; b = 16'h0017; start = 1'b1;
        for (int k = 0; k < 20 && t2 < 0; k++) begin
            @(negedge CLOCK_50);
            if (done && t1 < 0) begin
                t1 = k; s1 = sum;
                a = 16'h3456; b = 16'h5678;
            end else if (done) begin
                t2 = k; s2 = sum;
            end
            if (t1 >= 0 && k == t1 + 1 && (busy || done)) idle_busy++;
        end
        start = 1'b0;
        checks++;
        if (t2 - t1 !== 6 || t1 < 0) begin
            errors++; $display("FAIL b2b_spacing first=%0d second=%0d required gap 6", t1, t2);
        end
        checks++;
        if (idle_busy !== 0) begin errors++; $display("FAIL b2b_idle_accept busy_or_done=%0d required 0", idle_busy); end
        checks++;
        if ({s1, s2, cout} !== {16'h0042, 16'h9134, 1'b0}) begin
            errors++; $display("FAIL b2b_results first=%h second=%h cout=%b required 0042 9134 0", s1, s2, cout);
        end
        repeat (3) @(negedge CLOCK_50);
    endtask

    initial begin
        test_reset();
        test_add();
        test_carry_edges();
        test_ignore_start();
        test_input_hold();
        test_abort();
        test_invalid_digit();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_serial_add_ctrl.md
BCD_SERIAL_ADD_CTRL -- requirements
Module: bcd_serial_add_ctrl

Interface
REQ-001 Parameter NDIGITS, default 4, SHALL set the operand length in BCD digits; legal range is 1..8.
REQ-002 CLOCK_50  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 start  input  1  SHALL request an addition; sampled only in IDLE.
REQ-005 a  input  4*NDIGITS  SHALL be BCD operand A, digit 0 in bits [3:0].
REQ-006 b  input  4*NDIGITS  SHALL be BCD operand B, same packing as a.
REQ-007 busy  output  1  SHALL be high in every state except IDLE.
REQ-008 done  output  1  SHALL be a one-cycle completion pulse.
REQ-009 sum  output  4*NDIGITS  SHALL be the BCD result, same packing as a.
REQ-010 cout  output  1  SHALL be the decimal carry out of the most significant digit.
REQ-011 err  output  1  SHALL flag an operand digit greater than 9 (see Configuration).

Function
REQ-012 The FSM SHALL have exactly three states, IDLE, ADD and DONE, and SHALL reset to IDLE.
REQ-013 In IDLE with start=1, the block SHALL capture a and b into operand registers, clear the carry, clear the digit index and clear err, then go to ADD.
REQ-014 Each ADD cycle SHALL feed operand digit[idx] and the carry register to one shared digit adder.
- Write the result digit into sum digit[idx].
- Update the carry register.
- Increment idx.
REQ-015 After the cycle with idx=NDIGITS-1, the FSM SHALL go to DONE.
REQ-016 The digit adder SHALL compute s = a_d + b_d + cin as a 5-bit value.
- If s > 9: digit = (s+6)[3:0], carry = 1.
- Otherwise: digit = s[3:0], carry = 0.
REQ-017 DONE SHALL last one cycle with done=1, cout equal to the final carry, then return to IDLE.
REQ-018 Latency SHALL be NDIGITS+2 rising edges from the start sample to the done pulse (NDIGITS ADD cycles plus the capture and DONE cycles).
REQ-019 In DONE, sum, cout and err SHALL hold their values until the next accepted start.
REQ-020 start asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-021 start held high continuously SHALL begin a new operation in each IDLE cycle, giving back-to-back additions.
REQ-022 Inputs a and b SHALL be sampled only at capture; changes during ADD SHALL have no effect.
REQ-023 done and busy SHALL never be high in the same cycle as IDLE-state acceptance of a new start.

Reset
REQ-024 reset SHALL take priority over start in every state.
REQ-025 reset SHALL force: IDLE, busy=0, done=0, sum=0, cout=0, err=0, carry=0, idx=0.
REQ-026 A reset during ADD SHALL abort the operation with no done pulse.

Configuration
REQ-027 Macro BCD_INVALID_CHECK_EN SHALL control operand digit validation.
REQ-028 With BCD_INVALID_CHECK_EN defined:
- At capture, any digit > 9 in a or b SHALL skip ADD and go directly to DONE.
- In that case err=1, sum=0 and cout=0.
- The done pulse SHALL come on the 2nd edge after the start sample.
REQ-029 With BCD_INVALID_CHECK_EN undefined, err SHALL be tied 0 and all digits SHALL be processed per REQ-016.

Structure
REQ-030 Package bcd_pkg SHALL hold:
- typedef bcd_digit_t (logic [3:0]);
- enum state_t {IDLE, ADD, DONE};
- constant BCD_MAX = 4'd9;
- constant BCD_CORR = 4'd6.
REQ-031 The per-digit arithmetic SHALL be a separate combinational sub-module bcd_digit_adder, with ports a, b, cin, s, cout, instantiated exactly once.

Verification (NDIGITS=4)
REQ-032 a=16'h1234, b=16'h8766, start pulse -> done on the 6th edge, sum=16'h0000, cout=1, err=0.
REQ-033 a=16'h9999, b=16'h0001 -> sum=16'h0000, cout=1; a=16'h0000, b=16'h0000 -> sum=16'h0000, cout=0.
REQ-034 a=16'h0456, b=16'h0123, then start re-pulsed during ADD with a=16'h9999 -> single done with sum=16'h0579, cout=0.
REQ-035 reset asserted on the 2nd ADD cycle -> next cycle busy=0, sum=0, and no done pulse follows.
REQ-036 a=16'h00A0, b=16'h0000:
- Macro defined -> done on the 2nd edge, err=1, sum=0.
- Macro undefined -> sum=16'h0100, cout=0, err=0.
